// File: rtl/rr_arb_oh_pkg.sv
// Shared helpers for the round-robin one-hot arbiters: FSM encodings, one-hot to index
// conversion and the pointer rotation. Vectors are handled at a fixed width of MaxReq bits.
package rr_arb_oh_pkg;

    localparam int unsigned MaxReq      = 32;
    localparam int unsigned MaxIdxWidth = 5;

    localparam logic [0:0] ST_FREE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef logic [MaxReq-1:0]      req_vec_t;
    typedef logic [MaxIdxWidth-1:0] req_idx_t;

    // OR of the indices of all set bits; exact for one-hot input, zero for zero input.
    function automatic req_idx_t oh_to_idx(input req_vec_t oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < MaxReq; i++) begin
            if (oh[i]) idx |= req_idx_t'(i);
        end
        return idx;
    endfunction

    // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
    function automatic req_vec_t rotl1(input req_vec_t v, input int unsigned n);
        req_vec_t mask;
        mask = (n >= MaxReq) ? '1 : ((req_vec_t'(1) << n) - req_vec_t'(1));
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/rr_arb_oh_pick.sv
// Combinational one-hot priority pick: first set bit of req_i at or after ptr_oh_i,
// wrapping. Subtracting the pointer from the doubled request vector isolates the winner.
module oh_prio_pick #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] ptr_oh_i,
    output logic [NumReq-1:0] gnt_oh_o
);

    logic [2*NumReq-1:0] req_dbl;
    logic [2*NumReq-1:0] borrow;
    logic [2*NumReq-1:0] win_dbl;

    assign req_dbl = {req_i, req_i};
    // The borrow ripples from the pointer up to the first request, clearing exactly that bit.
    assign borrow  = req_dbl - {{NumReq{1'b0}}, ptr_oh_i};
    assign win_dbl = req_dbl & ~borrow;

    // Upper-half hits are the wrapped-around winners.
    assign gnt_oh_o = win_dbl[NumReq-1:0] | win_dbl[2*NumReq-1:NumReq];

endmodule

// File: rtl/rr_arb_oh.sv
// Round-robin arbiter with one-hot grant (mux select) and valid/ready merge; grant is held
// while stalled. Optional packet lock with per-beat last flags: define RR_ARB_PKT_LOCK_EN.
module rr_arb_oh
    import rr_arb_oh_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumReq-1:0]   req_valid_i,
`ifdef RR_ARB_PKT_LOCK_EN
    input  logic [NumReq-1:0]   req_last_i,
`endif
    output logic [NumReq-1:0]   req_ready_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [NumReq-1:0]   grant_oh_o,
    output logic [IdxWidth-1:0] grant_idx_o
);

    logic [NumReq-1:0] ptr_q, ptr_d;
    logic [0:0]        lock_q, lock_d;
    logic [NumReq-1:0] locked_grant_q, locked_grant_d;

    logic [NumReq-1:0] pick_oh;
    logic [NumReq-1:0] grant_oh;
    logic              handshake;
    logic              last_beat;

    oh_prio_pick #(
        .NumReq(NumReq)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_oh_i(ptr_q),
        .gnt_oh_o(pick_oh)
    );

    // Gated by rst_n so every output is quiet for the whole time reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        grant_oh = '0;
        if (rst_n) begin
            grant_oh = (lock_q == ST_LOCKED) ? locked_grant_q : pick_oh;
        end
    end

    assign grant_oh_o  = grant_oh;
    assign grant_idx_o = IdxWidth'(oh_to_idx(req_vec_t'(grant_oh)));
    assign out_valid_o = |(grant_oh & req_valid_i);
    assign req_ready_o = grant_oh & {NumReq{out_ready_i}};
    assign handshake   = out_valid_o & out_ready_i;

`ifdef RR_ARB_PKT_LOCK_EN
    assign last_beat = |(grant_oh & req_last_i);
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        ptr_d          = ptr_q;
        lock_d         = lock_q;
        locked_grant_d = locked_grant_q;

        // The winner of a completed transfer drops to lowest priority.
        if (handshake && last_beat) begin
            ptr_d = NumReq'(rotl1(req_vec_t'(grant_oh), NumReq));
        end

`ifdef RR_ARB_PKT_LOCK_EN
        // Packet mode: once granted, stay locked until the last beat is accepted.
        if (lock_q == ST_LOCKED) begin
            if (handshake && last_beat) lock_d = ST_FREE;
        end else if (out_valid_o && !(handshake && last_beat)) begin
            lock_d         = ST_LOCKED;
            locked_grant_d = grant_oh;
        end
`else
        // Stalled transfer: hold; handshake or a dropped valid releases.
        if (lock_q == ST_LOCKED) begin
            if (handshake || !out_valid_o) lock_d = ST_FREE;
        end else if (out_valid_o && !out_ready_i) begin
            lock_d         = ST_LOCKED;
            locked_grant_d = grant_oh;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= NumReq'(1);
            lock_q         <= ST_FREE;
            locked_grant_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignments so all of them update from
            // the same pre-edge values, independent of statement order.
            ptr_q          <= ptr_d;
            lock_q         <= lock_d;
            locked_grant_q <= locked_grant_d;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_oh));

`ifdef RR_ARB_PKT_LOCK_EN
    // Valid may dip between beats of a locked packet, so only free-running grants are checked.
    a_grant_subset: assert property (@(posedge clk) disable iff (!rst_n)
        (lock_q == ST_FREE) |-> ((grant_oh & ~req_valid_i) == '0));
`else
    a_grant_subset: assert property (@(posedge clk) disable iff (!rst_n)
        (grant_oh & ~req_valid_i) == '0);
`endif
`endif

endmodule

// File: doc/rr_arb_oh.md
Name: rr_arb_oh

Overview:
- Round-robin arbiter producing a one-hot grant vector, sitting directly upstream of the one-hot data mux.
- N requesters present valid/ready streams; the arbiter picks one and drives the one-hot select that the mux uses to steer that requester's payload.
- Merges these streams onto one valid/ready output port.
- Holds the grant stable while the output is stalled.
- Advances fairness priority only on a completed handshake.

Parameters:
- NumReq, 4, number of requesters; must be >= 1.
- IdxWidth, (NumReq > 1) ? $clog2(NumReq) : 1, width of the binary grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  NumReq  per-requester valid.
- req_ready_o  output  NumReq  per-requester ready; at most one bit set.
- out_valid_o  output  1  merged output valid.
- out_ready_i  input  1  downstream ready.
- grant_oh_o  output  NumReq  one-hot grant, used directly as the mux select; all-zero when no request.
- grant_idx_o  output  IdxWidth  binary index of grant_oh_o bit; 0 when no grant.

Behaviour:
Reset:
- One clock; reset asynchronous active-low.
- On reset: ptr_q = one-hot bit 0, lock_q = 0, locked_grant_q = 0.
- Consequently out_valid_o = 0, req_ready_o = 0, grant_oh_o = 0 and grant_idx_o = 0 while rst_n low, irrespective of req_valid_i.
- Reset mid-transaction drops the lock; no handshake completes in the reset cycle.

State (two states):
- FREE (lock_q = 0).
- LOCKED (lock_q = 1).

Grant computation in FREE:
- Combinational.
- Pick the first set bit of req_valid_i at or after the position of ptr_q, wrapping from NumReq-1 to 0. This is a masked priority pick plus an unmasked fallback.
- Zero latency: grant is visible in the same cycle the request rises.

Grant computation in LOCKED:
- grant_oh_o = locked_grant_q, regardless of the other requests.

Outputs:
- out_valid_o = |(grant_oh_o & req_valid_i).
- req_ready_o = grant_oh_o & {NumReq{out_ready_i}}.

Transitions:
- FREE -> LOCKED when out_valid_o & ~out_ready_i. Capture grant_oh_o into locked_grant_q.
- LOCKED -> FREE on handshake (out_valid_o & out_ready_i).
- Handshake in either state: ptr_q <= grant rotated left by 1, with wrap, so the winner becomes lowest priority.
- No handshake: ptr_q holds.

Boundary conditions:
- No requests: grant all-zero, ptr_q holds.
- Single requester continuously valid: granted every cycle; ptr_q moves past it, then wraps back to it.
- Locked requester drops valid (protocol violation):
  - out_valid_o falls and the lock releases the next cycle.
  - A simulation-only assertion fires.
- NumReq = 1: grant_oh_o = req_valid_i, grant_idx_o = 0, pointer constant.

Invariants (asserted):
- $onehot0(grant_oh_o).
- grant_oh_o subset of req_valid_i, except in the violation case.

Optional Feature:
- Macro: RR_ARB_PKT_LOCK_EN.
- When defined:
  - Adds input req_last_i [NumReq].
  - The lock persists across handshakes until a handshake with req_last_i[grant] = 1.
  - ptr_q advances only on that last beat, so multi-beat packets are never interleaved.
  - Between beats in LOCKED, grant stays asserted even if the requester's valid is momentarily low; this is legal in this mode.
- When not defined:
  - No req_last_i port.
  - Every handshake is treated as a last beat (behaviour as above).

Decomposition:
- Shared package: function for one-hot-to-index conversion; a rotate-left-by-one function for the pointer.
- One natural sub-module, oh_prio_pick:
  - Inputs: request vector and one-hot start pointer.
  - Output: one-hot winner.
  - Purely combinational, double-width mask trick.
  - Reused by other arbiters in the codebase.

Test Plan:
1. Reset: rst_n = 0 with req_valid_i = 4'b1111 -> grant_oh_o = 0, out_valid_o = 0, req_ready_o = 0; release reset -> grant_oh_o = 4'b0001, grant_idx_o = 0.
2. Fairness: req_valid_i = 4'b1111, out_ready_i = 1 constantly -> grants over 8 cycles are 0001, 0010, 0100, 1000, 0001, ... with one handshake per cycle.
3. Stall lock: req_valid_i = 4'b0101, out_ready_i = 0 for 3 cycles, then raise req 1 -> grant_oh_o stays 4'b0001 throughout; when out_ready_i = 1, handshake on req 0, and the next grant is 4'b0010.
4. Wrap/skip: ptr_q at bit 3, req_valid_i = 4'b0010 -> grant 4'b0010 the same cycle, and ptr_q becomes bit 2 after the handshake.
5. Async reset mid-lock: LOCKED on requester 2, pull rst_n low between clock edges -> outputs zero immediately; after release, arbitration restarts from bit 0.
6. RR_ARB_PKT_LOCK_EN: req 0 sends 3 beats (last on beat 3) while req 1 is valid -> req 1 is not granted until after beat 3's handshake.
